// File: rtl/flash_spi_pkg.sv
// flash_spi_pkg: register offsets, status bit positions and shifter states for flash_spi
package flash_spi_pkg;
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_DATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam int ST_BUSY = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_OVERRUN = 2;
  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_e;
endpackage

// File: rtl/flash_spi_shifter.sv
// flash_spi_shifter: mode-0 byte shifter with programmable half-period divider
module flash_spi_shifter
  import flash_spi_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           tx_byte,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 miso,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           rx_byte,
  output logic                 sclk,
  output logic                 mosi
);
  state_e state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d, rx_q, rx_d;
  logic sclk_q, sclk_d, mosi_q, mosi_d;
  logic phase_end;
  assign phase_end = cnt_q == div;
  always_comb begin
    state_d = state_q;
    cnt_d = phase_end ? '0 : cnt_q + 1'b1;
    bit_d = bit_q;
    tx_d = tx_q;
    rx_d = rx_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    done = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = LOW;
          bit_d = '0;
          tx_d = tx_byte;
          mosi_d = tx_byte[7];
        end
      end
      LOW: if (phase_end) begin
        state_d = HIGH;
        sclk_d = 1'b1;
        rx_d = {rx_q[6:0], miso};
      end
      HIGH: if (phase_end) begin
        sclk_d = 1'b0;
        if (bit_q == 3'd7) begin
          state_d = IDLE;
          done = 1'b1;
        end else begin
          state_d = LOW;
          bit_d = bit_q + 3'd1;
          tx_d = {tx_q[6:0], 1'b0};
          mosi_d = tx_q[6];
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
    end
  end
  assign busy = state_q != IDLE;
  assign rx_byte = rx_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;
endmodule

// File: rtl/flash_spi.sv
// flash_spi: memory-mapped SPI master for the configuration flash (register decode and status flags)
module flash_spi
  import flash_spi_pkg::*;
#(
  parameter int                   DIV_WIDTH = 8,
  parameter logic [DIV_WIDTH-1:0] DIV_RESET = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        flash_clk,
  output logic        flash_csn,
  output logic        flash_io0_out,
  output logic        flash_io0_en,
  input  logic        flash_io1_in
);
  logic [1:0] off;
  logic busy, done, start, wr_ctrl, wr_data, rd_data, clr_ovr;
  logic [7:0] rx_byte;
  logic cs_q, cs_d, rx_valid_q, rx_valid_d, overrun_q, overrun_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [2:0] status;
  logic unused_ok;
  assign unused_ok = ^{address_in, write_value_in, write_mask_in};
  assign off = address_in[3:2];
  assign wr_ctrl = sel_in & (off == REG_CTRL) & ~busy;
  assign wr_data = sel_in & (off == REG_DATA) & write_mask_in[0];
  assign rd_data = sel_in & read_in & (off == REG_DATA);
  assign clr_ovr = sel_in & (off == REG_STATUS) & write_mask_in[0] & write_value_in[ST_OVERRUN];
  assign start = wr_data & ~busy;
  flash_spi_shifter #(.DIV_WIDTH(DIV_WIDTH)) u_shifter (
    .clk(clk), .reset(reset), .start(start), .tx_byte(write_value_in[7:0]), .div(div_q),
    .miso(flash_io1_in), .busy(busy), .done(done), .rx_byte(rx_byte), .sclk(flash_clk),
    .mosi(flash_io0_out)
  );
  always_comb begin
    cs_d = (wr_ctrl & write_mask_in[0]) ? write_value_in[0] : cs_q;
    div_d = (wr_ctrl & write_mask_in[1]) ? write_value_in[8 +: DIV_WIDTH] : div_q;
    rx_data_d = done ? rx_byte : rx_data_q;
    // completion wins over a simultaneous DATA read; a write landing on the final cycle still overruns
    rx_valid_d = done | (rx_valid_q & ~rd_data);
    overrun_d = (wr_data & busy) | (overrun_q & ~clr_ovr);
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_RX_VALID] = rx_valid_q;
    status[ST_OVERRUN] = overrun_q;
    read_value_out = !sel_in ? 32'h0 :
                     off == REG_CTRL ? {{(24-DIV_WIDTH){1'b0}}, div_q, 7'b0, cs_q} :
                     off == REG_DATA ? {24'b0, rx_data_q} :
                     off == REG_STATUS ? {29'b0, status} : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q <= 1'b0;
      div_q <= DIV_RESET;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cs_q <= cs_d;
      div_q <= div_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q <= overrun_d;
    end
  end
  assign flash_csn = ~cs_q;
  assign flash_io0_en = cs_q;
endmodule

// File: tb/tb_flash_spi.sv
// tb_flash_spi: randomized bus traffic checked against a transfer-level model, plus directed literal checks
module tb_flash_spi;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] address_in = '0, write_value_in = '0, read_value_out;
  logic sel_in = 1'b0, read_in = 1'b0, flash_io1_in = 1'b0;
  logic [3:0] write_mask_in = '0;
  logic flash_clk, flash_csn, flash_io0_out, flash_io0_en;
  logic [7:0] miso_byte = '0, mosi_cap = '0;
  int checks = 0, failures = 0, hi_cnt = 0;
  always #5 clk = ~clk;

  flash_spi dut (
    .clk(clk), .reset(reset), .address_in(address_in), .sel_in(sel_in), .read_in(read_in),
    .read_value_out(read_value_out), .write_mask_in(write_mask_in), .write_value_in(write_value_in),
    .flash_clk(flash_clk), .flash_csn(flash_csn), .flash_io0_out(flash_io0_out),
    .flash_io0_en(flash_io0_en), .flash_io1_in(flash_io1_in)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transfer-level model: a byte is 16 half-periods of (div+1) cycles, counted by m_k
  bit m_cs, m_rxv, m_ovr, m_act, m_mosi, m_ok;
  bit [7:0] m_div, m_rx, m_tx, m_tdiv, m_miso;
  int m_k;

  function automatic int phase();
    return m_act ? m_k / (int'(m_tdiv) + 1) : 0;
  endfunction

  always @(posedge clk) begin : model
    bit [1:0] off;
    bit last, start;
    off = address_in[3:2];
    if (reset) begin
      m_cs = 0; m_div = 0; m_rx = 0; m_rxv = 0; m_ovr = 0; m_act = 0; m_mosi = 0; m_k = 0; m_ok = 1;
    end else begin
      last = m_act && (m_k == 16 * (int'(m_tdiv) + 1) - 1);
      start = sel_in && write_mask_in[0] && off == 2'd1 && !m_act;
      if (sel_in && write_mask_in[0] && off == 2'd2 && write_value_in[2]) m_ovr = 0;
      if (sel_in && write_mask_in[0] && off == 2'd1 && m_act) m_ovr = 1;
      if (sel_in && read_in && off == 2'd1) m_rxv = 0;
      if (sel_in && !m_act && off == 2'd0) begin
        if (write_mask_in[0]) m_cs = write_value_in[0];
        if (write_mask_in[1]) m_div = write_value_in[15:8];
      end
      if (last) begin
        m_act = 0; m_rx = m_miso; m_rxv = 1; m_mosi = m_tx[0];
      end else if (m_act) m_k++;
      else if (start) begin
        m_act = 1; m_k = 0; m_tx = write_value_in[7:0]; m_tdiv = m_div; m_miso = miso_byte;
      end
    end
  end

  always @(negedge clk) begin : compare
    int ph;
    logic [31:0] e_rd;
    ph = phase();
    case (address_in[3:2])
      2'd0: e_rd = {16'b0, m_div, 7'b0, m_cs};
      2'd1: e_rd = {24'b0, m_rx};
      2'd2: e_rd = {29'b0, m_ovr, m_rxv, m_act};
      default: e_rd = 32'h0;
    endcase
    if (!sel_in) e_rd = 32'h0;
    if (m_ok) begin
      chk("flash_clk", {31'b0, flash_clk}, {31'b0, m_act && (ph % 2 == 1)});
      chk("flash_csn", {31'b0, flash_csn}, {31'b0, !m_cs});
      chk("io0_en", {31'b0, flash_io0_en}, {31'b0, m_cs});
      chk("mosi", {31'b0, flash_io0_out}, {31'b0, m_act ? m_tx[7 - ph / 2] : m_mosi});
      chk("read_value", read_value_out, e_rd);
    end
    if (flash_clk) hi_cnt++;
    flash_io1_in = m_act ? m_miso[7 - ph / 2] : 1'b0;
  end

  always @(posedge flash_clk) mosi_cap = {mosi_cap[6:0], flash_io0_out};

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] off, input logic [3:0] mask, input logic [31:0] val);
    sel_in = 1; read_in = 0; address_in = {28'h0004_000, off, 2'b00}; write_mask_in = mask; write_value_in = val;
    step(1);
    sel_in = 0; write_mask_in = 0;
  endtask

  task automatic rd(input logic [1:0] off, output logic [31:0] v);
    sel_in = 1; read_in = 1; write_mask_in = 0; address_in = {28'h0004_000, off, 2'b00};
    @(negedge clk);
    v = read_value_out;
    step(1);
    sel_in = 0; read_in = 0;
  endtask

  task automatic poll(output int n);
    logic [31:0] v;
    n = 0;
    v = 32'h1;
    for (int i = 0; i < 5000; i++) begin
      rd(2'd2, v);
      if (!v[0]) break;
      n++;
    end
    chk("poll_bounded", {31'b0, v[0]}, 32'h0);
  endtask

  initial begin
    logic [31:0] v;
    int n;
    step(3);
    reset = 0;
    chk("rst_csn", {31'b0, flash_csn}, 32'h1);
    chk("rst_clk", {31'b0, flash_clk}, 32'h0);
    rd(2'd2, v); chk("rst_status", v, 32'h0);
    rd(2'd0, v); chk("rst_ctrl", v, 32'h0);
    // single byte, div=0
    wr(2'd0, 4'h3, 32'h1);
    miso_byte = 8'hA5; mosi_cap = 0;
    wr(2'd1, 4'h1, 32'h9F);
    poll(n);
    chk("busy_len_div0", n, 16);
    chk("mosi_byte", {24'b0, mosi_cap}, 32'h9F);
    rd(2'd2, v); chk("status_rxv", v, 32'h2);
    rd(2'd1, v); chk("rx_a5", v, 32'hA5);
    rd(2'd2, v); chk("status_clr", v, 32'h0);
    // divider 3
    wr(2'd0, 4'h3, 32'h0301);
    hi_cnt = 0;
    wr(2'd1, 4'h1, 32'h00);
    poll(n);
    chk("busy_len_div3", n, 64);
    chk("clk_high_cycles", hi_cnt, 32);
    rd(2'd1, v);
    // overrun
    wr(2'd0, 4'h3, 32'h0001);
    mosi_cap = 0; miso_byte = 8'h5A;
    wr(2'd1, 4'h1, 32'h3C);
    step(4);
    wr(2'd1, 4'h1, 32'hFF);
    poll(n);
    chk("ovr_mosi", {24'b0, mosi_cap}, 32'h3C);
    rd(2'd2, v); chk("ovr_status", v, 32'h6);
    wr(2'd2, 4'h1, 32'h4);
    rd(2'd2, v); chk("ovr_cleared", v, 32'h2);
    rd(2'd1, v); chk("ovr_rx", v, 32'h5A);
    // CTRL while busy
    wr(2'd1, 4'h1, 32'h11);
    step(3);
    wr(2'd0, 4'h1, 32'h0);
    chk("csn_held", {31'b0, flash_csn}, 32'h0);
    poll(n);
    chk("csn_after_byte", {31'b0, flash_csn}, 32'h0);
    wr(2'd0, 4'h1, 32'h0);
    chk("csn_raised", {31'b0, flash_csn}, 32'h1);
    rd(2'd1, v);
    // reset mid-transfer
    wr(2'd0, 4'h1, 32'h1);
    wr(2'd1, 4'h1, 32'hC3);
    step(6);
    reset = 1;
    step(1);
    reset = 0;
    chk("rst_mid_clk", {31'b0, flash_clk}, 32'h0);
    chk("rst_mid_csn", {31'b0, flash_csn}, 32'h1);
    rd(2'd2, v); chk("rst_mid_status", v, 32'h0);
    // bus isolation
    wr(2'd0, 4'h1, 32'h1);
    miso_byte = 8'h77;
    wr(2'd1, 4'h1, 32'h12);
    poll(n);
    sel_in = 0; read_in = 1; address_in = 32'h0004_0004;
    @(negedge clk);
    chk("iso_zero", read_value_out, 32'h0);
    step(1);
    read_in = 0;
    rd(2'd2, v); chk("iso_rxv_kept", v, 32'h2);
    rd(2'd1, v); chk("iso_rx", v, 32'h77);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      sel_in = $urandom_range(0, 9) != 0;
      read_in = $urandom_range(0, 1) == 1;
      address_in = {28'h0004_000, 2'($urandom_range(0, 3)), 2'b00};
      write_mask_in = 4'($urandom);
      write_value_in = {16'($urandom), 8'($urandom_range(0, 2)), 8'($urandom)};
      miso_byte = 8'($urandom);
      reset = $urandom_range(0, 149) == 0;
      step(1);
      sel_in = 0; read_in = 0; write_mask_in = 0; reset = 0;
      if ($urandom_range(0, 3) == 0) step($urandom_range(1, 20));
    end
    step(200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/flash_spi.md
Name: flash_spi

Overview:
- Memory-mapped SPI master that drives the serial configuration flash (flash_clk, flash_csn, io0 = MOSI, io1 = MISO).
- Attached to the common memory bus as a peripheral alongside ram, uart and timer.
- Firmware controls the transfer byte by byte:
  - assert CS;
  - write a TX byte, poll busy, read the RX byte;
  - deassert CS.
- Sits directly downstream of the bus address decode and directly upstream of the flash SB_IO pads.

Parameters:
- DIV_WIDTH, 8: width of the clock divider field.
- DIV_RESET, 0: reset value of the divider. SPI half-period is (div+1) clk cycles.

Ports:
- clk  in  1  system clock (pll_clk domain).
- reset  in  1  synchronous, active-high reset.
- address_in  in  32  bus address; only bits [3:2] are decoded.
- sel_in  in  1  block selected by the top-level decode (region 0x0004_0000-0x0004_000F).
- read_in  in  1  bus read strobe.
- read_value_out  out  32  read data; all zeros when sel_in=0 (wired-OR bus).
- write_mask_in  in  4  byte write enables.
- write_value_in  in  32  write data.
- flash_clk  out  1  SPI clock, mode 0 (idle low).
- flash_csn  out  1  chip select, active low.
- flash_io0_out  out  1  MOSI data.
- flash_io0_en  out  1  MOSI output enable; equals ~flash_csn.
- flash_io1_in  in  1  MISO data.

Behaviour:
- Reset values: flash_clk=0, flash_csn=1, flash_io0_out=0, flash_io0_en=0; divider=DIV_RESET; rx_data=0; busy=0, rx_valid=0, overrun=0; FSM=IDLE. A reset mid-transfer aborts the byte at the next edge.
- Register map (word offsets):
  - 0x0 CTRL: bit0 cs (flash_csn=~cs); bits[8+DIV_WIDTH-1:8] div. Write requires mask[0] for cs and mask[1] for div. The whole write is ignored while busy.
  - 0x4 DATA: write with mask[0] while idle loads tx=[7:0] and starts a transfer. Read returns {24'b0, rx_data}. A read (sel_in & read_in) clears rx_valid.
  - 0x8 STATUS: bit0 busy, bit1 rx_valid, bit2 overrun. Writing 1 to bit2 (mask[0]) clears overrun.
  - 0xC: reads 0; writes are ignored.
- read_value_out is combinational from the registers, gated by sel_in; read latency matches ram (same cycle).
- FSM states: IDLE, LOW, HIGH. div_cnt counts 0..div; a phase ends when div_cnt==div.
  - IDLE -> LOW on DATA write: busy=1, io0_out=tx[7], bit_cnt=0.
  - LOW end -> HIGH: flash_clk=1, rx_shift={rx_shift[6:0], flash_io1_in}.
  - HIGH end with bit_cnt!=7 -> LOW: flash_clk=0, io0_out=next tx bit (MSB first), bit_cnt+1.
  - HIGH end with bit_cnt==7 -> IDLE: flash_clk=0, rx_data=shifted byte, busy=0, rx_valid=1.
- Byte duration: busy is high for exactly 16*(div+1) cycles, starting the cycle after the DATA write.
- A DATA write while busy is ignored (tx unchanged) and sets overrun (sticky).
- Completion and a DATA read in the same cycle: rx_valid=1 (set wins).
- Completion and a DATA write in the same cycle: the write counts as busy, so overrun is set.
- flash_csn changes only via CTRL, never automatically; flash_clk is always low when cs toggles.
- div changes take effect from the next transfer.

Decomposition:
- Package flash_spi_pkg holds:
  - register offset constants (CTRL/DATA/STATUS);
  - STATUS bit indices;
  - the FSM state enum {IDLE, LOW, HIGH}.
- One sub-module, flash_spi_shifter, contains the divider counter, FSM and tx/rx shift registers.
  - Interface: start, tx_byte, div, miso in; busy, done pulse, rx_byte, sclk, mosi out.
- flash_spi itself holds the register decode and the status flags.

Test Plan:
- Reset: after reset is released -> flash_csn=1, flash_clk=0, STATUS reads 0x0, CTRL reads 0x0 with DIV_RESET=0.
- Single byte, div=0, MISO model returns 0xA5:
  - write CTRL=1, DATA=0x9F;
  - MOSI on the rising edges of flash_clk = 1,0,0,1,1,1,1,1;
  - busy is high for exactly 16 cycles;
  - then STATUS=0x2 and a DATA read gives 0xA5, after which STATUS=0x0.
- Divider: CTRL=0x0301 (div=3) then DATA=0x00 -> flash_clk high and low phases are each 4 cycles; busy is high for 64 cycles.
- Overrun: second DATA write 5 cycles after the first -> STATUS bit2=1, the transmitted byte is still the first one; writing STATUS=0x4 clears the bit.
- CTRL while busy: write CTRL=0 mid-byte -> flash_csn stays 0 until the byte ends, then a new CTRL=0 write raises it.
- Reset mid-transfer: assert reset at cycle 7 of a byte -> next cycle flash_clk=0, flash_csn=1, busy=0, rx_valid=0.
- Bus isolation: sel_in=0 with read_in=1 -> read_value_out=0 and no flag is cleared.
